branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters for the 5-stage pipeline.
- Fetch stage: predicts next-PC from PCF.
- Execute stage: compares the prediction against the resolved outcome (PCSrcE, produced by the execute-stage jump/branch resolution logic), then trains the table.
- Raises MispredictE with the corrected PC. The hazard unit uses it to flush the Decode and Execute stages.

Parameters:
- XLEN, 32, address/data width.
- IDX_BITS, 4, BTB index width; 2**IDX_BITS entries.
- CNT_BITS, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- PCF  input  XLEN  fetch-stage PC.
- PredTakenF  output  1  prediction: redirect fetch.
- PredTargetF  output  XLEN  predicted target; valid when PredTakenF=1.
- ValidE  input  1  execute-stage instruction is real (not a bubble or flushed).
- PCE  input  XLEN  execute-stage PC.
- JumpE  input  2  01=jal, 10=jalr, 00=none.
- BranchE  input  2  01=beq-type, 10=bne-type, 00=none.
- PCSrcE  input  2  resolved next-PC select; 00=PC+4, 01=PCTarget, 10=ALU result.
- ActualTargetE  input  XLEN  resolved taken target; datapath muxes PCTargetE or ALU result.
- PredTakenE  input  1  PredTakenF carried down the pipeline.
- PredTargetE  input  XLEN  PredTargetF carried down the pipeline.
- MispredictE  output  1  prediction wrong; flush D/E and redirect.
- RedirectPCE  output  XLEN  correct next PC when MispredictE=1.
- BranchCount  output  CNT_BITS  resolved control-flow instructions.
- MispredCount  output  CNT_BITS  mispredictions.

Behaviour:
- Entry fields: valid (1), tag (XLEN-IDX_BITS-2), target (XLEN), ctr (2).
- Addressing: index = PC[IDX_BITS+1:2]; tag = PC[XLEN-1:IDX_BITS+2].
- Lookup (combinational, same cycle):
  - hitF = valid[idx] & (tag[idx]==tagF).
  - PredTakenF = hitF & ctr[idx][1].
  - PredTargetF = target[idx] when hitF, else 0.
- Resolve (combinational), qualified by resE = ValidE & (JumpE!=0 | BranchE!=0):
  - takenE = (PCSrcE != 00).
  - MispredictE = ValidE & ((PredTakenE != takenE) | (takenE & PredTakenE & PredTargetE != ActualTargetE)).
  - A non-control instruction with PredTakenE=1 (stale alias) also mispredicts, with takenE=0.
  - RedirectPCE = takenE ? ActualTargetE : PCE+4.
  - MispredictE=0 and RedirectPCE=PCE+4 when ValidE=0.
- Update (rising clk, only when resE=1; entry selected by PCE index):
  - Hit, taken: ctr saturating increment (11 stays 11); target <= ActualTargetE.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace. valid<=1, tag<=PCE tag, target<=ActualTargetE, ctr<=10.
  - Miss, not taken: no change.
  - jal/jalr always resolve taken (PCSrcE != 00), so they train toward 11.
- Invalidation: ValidE=1 with no jump/branch and a hit on PCE: entry valid<=0. This removes aliasing that mispredicted a non-branch.
- Statistics:
  - BranchCount increments per resE cycle.
  - MispredCount increments per MispredictE cycle.
  - Both saturate at all-ones.
- Read/write collision: same-cycle write and lookup of the same index. Lookup sees pre-edge contents; no bypass. The write is visible the following cycle.
- Reset (rst=0, asynchronous, any cycle including mid-update):
  - All valid<=0, ctr<=01, targets/tags<=0, counters<=0.
  - Outputs immediately: PredTakenF=0, PredTargetF=0. MispredictE and RedirectPCE follow their inputs, since they are combinational.
- No stall input. The pipeline must hold ValidE=0 for a stalled or flushed E stage so no double update occurs.

Test Plan:
- Reset, then PCF=0x40 -> PredTakenF=0, PredTargetF=0; BranchCount=MispredCount=0.
- Resolve beq at PCE=0x40, PCSrcE=01, ActualTargetE=0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x80 (ctr=10).
- Same branch resolved taken twice more, then not-taken twice -> ctr 11,11,10,01. PredTakenF sequence 1,1,1,0. Final not-taken resolve gives MispredictE=1, RedirectPCE=0x44.
- jalr at 0x100 predicted target 0x200, ActualTargetE=0x300 -> MispredictE=1, RedirectPCE=0x300. Entry target becomes 0x300.
- Aliasing: entry for 0x40 (IDX_BITS=4); PCE=0x440 with ValidE=1 and non-control -> hit invalidated, but the tag differs so no change. Then PCE=0x40 non-control -> valid cleared, PredTakenF=0.
- Assert rst low mid-update at PCE=0x40 -> table cleared, counters 0, PredTakenF=0 before the next edge. Statistics saturate at 0xFFFF after 65536+ branches.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline (fetch/execute stages) and the branch
// predictor. The predictor takes the slave side; the pipeline drives master.
interface branch_predictor_if #(
  parameter int XLEN     = 32,
  parameter int CNT_BITS = 16
);
  // Fetch-stage lookup
  logic [XLEN-1:0]     PCF;
  logic                PredTakenF;
  logic [XLEN-1:0]     PredTargetF;

  // Execute-stage resolution
  logic                ValidE;
  logic [XLEN-1:0]     PCE;
  logic [1:0]          JumpE;
  logic [1:0]          BranchE;
  logic [1:0]          PCSrcE;
  logic [XLEN-1:0]     ActualTargetE;
  logic                PredTakenE;
  logic [XLEN-1:0]     PredTargetE;
  logic                MispredictE;
  logic [XLEN-1:0]     RedirectPCE;

  // Statistics
  logic [CNT_BITS-1:0] BranchCount;
  logic [CNT_BITS-1:0] MispredCount;

  modport slave (
    input  PCF, ValidE, PCE, JumpE, BranchE, PCSrcE, ActualTargetE,
           PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE,
           BranchCount, MispredCount
  );

  modport master (
    output PCF, ValidE, PCE, JumpE, BranchE, PCSrcE, ActualTargetE,
           PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE,
           BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters. Fetch looks up
// the next PC combinationally; execute checks the carried prediction against
// the resolved outcome, raises a redirect on mismatch and trains the table.
// The interface instance must use the same XLEN/CNT_BITS as this module.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active-low
  branch_predictor_if.slave bp
);

  localparam int TAG_BITS = XLEN - IDX_BITS - 2;
  localparam int ENTRIES  = 1 << IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t              btb_q [ENTRIES];
  entry_t              entry_d;
  logic                wr_en_d;
  logic [CNT_BITS-1:0] branch_cnt_q;
  logic [CNT_BITS-1:0] mispred_cnt_q;

  // ---------------------------------------------------------------- fetch
  logic [IDX_BITS-1:0] idx_f;
  logic [TAG_BITS-1:0] tag_f;
  entry_t              entry_f;
  logic                hit_f;

  assign idx_f   = bp.PCF[IDX_BITS+1:2];
  assign tag_f   = bp.PCF[XLEN-1:IDX_BITS+2];
  assign entry_f = btb_q[idx_f];
  assign hit_f   = entry_f.valid && (entry_f.tag == tag_f);

  assign bp.PredTakenF  = hit_f && entry_f.ctr[1];
  assign bp.PredTargetF = hit_f ? entry_f.target : '0;

  // Instructions are word aligned, so the byte offset never selects an entry.
  logic unused_pcf_lsb;
  assign unused_pcf_lsb = ^bp.PCF[1:0];

  // -------------------------------------------------------------- execute
  logic [IDX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0] tag_e;
  entry_t              entry_e;
  logic                hit_e;
  logic                is_ctrl_e;
  logic                res_e;
  logic                taken_e;
  logic                target_wrong_e;

  assign idx_e   = bp.PCE[IDX_BITS+1:2];
  assign tag_e   = bp.PCE[XLEN-1:IDX_BITS+2];
  assign entry_e = btb_q[idx_e];
  assign hit_e   = entry_e.valid && (entry_e.tag == tag_e);

  assign is_ctrl_e = (bp.JumpE != 2'b00) || (bp.BranchE != 2'b00);
  assign res_e     = bp.ValidE && is_ctrl_e;
  // A non-control instruction is never taken, whatever PCSrcE says; a stale
  // aliased prediction on it therefore shows up as a direction mispredict.
  assign taken_e   = res_e && (bp.PCSrcE != 2'b00);

  assign target_wrong_e = taken_e && bp.PredTakenE &&
                          (bp.PredTargetE != bp.ActualTargetE);

  assign bp.MispredictE = bp.ValidE &&
                          ((bp.PredTakenE != taken_e) || target_wrong_e);
  assign bp.RedirectPCE = taken_e ? bp.ActualTargetE : bp.PCE + XLEN'(4);

  // Compute the trained version of the execute-stage entry and whether to write it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    entry_d = entry_e;
    wr_en_d = 1'b0;
    if (res_e) begin
      if (hit_e) begin
        wr_en_d = 1'b1;
        if (taken_e) begin
          if (entry_e.ctr != 2'b11) entry_d.ctr = entry_e.ctr + 2'd1;
          entry_d.target = bp.ActualTargetE;
        end else if (entry_e.ctr != 2'b00) begin
          entry_d.ctr = entry_e.ctr - 2'd1;
        end
      end else if (taken_e) begin
        wr_en_d = 1'b1;
        entry_d = '{valid: 1'b1, tag: tag_e, target: bp.ActualTargetE, ctr: 2'b10};
      end
    end else if (bp.ValidE && hit_e) begin
      // A real non-branch hit this entry: it is an alias, drop it.
      wr_en_d       = 1'b1;
      entry_d.valid = 1'b0;
    end
  end

  // Table storage: cleared on reset, one entry written per cycle at the PCE index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the table is reset because stale valid bits would otherwise
      // produce predictions straight out of reset; 16 entries make this cheap.
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (wr_en_d) begin
      // NOTE: sequential state uses non-blocking assignments so the same-edge
      // fetch lookup still sees the pre-edge table (no bypass).
      btb_q[idx_e] <= entry_d;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (res_e && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_BITS'(1);
      end
      if (bp.MispredictE && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_BITS'(1);
      end
    end
  end

  assign bp.BranchCount  = branch_cnt_q;
  assign bp.MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic, checked by a scoreboard fed from a behavioural table model.
module tb_branch_predictor;

  localparam int XLEN = 32;
  localparam int IDX  = 4;
  localparam int ENT  = 16;
  localparam int CMAX = 65535;

  logic clk;
  logic rst;

  branch_predictor_if #(.XLEN(XLEN), .CNT_BITS(16)) bp_if ();

  branch_predictor #(.XLEN(XLEN), .IDX_BITS(IDX), .CNT_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------- reference
  // One record per table slot; the direction counter is a plain integer 0..3.
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  int          m_bc;
  int          m_mc;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Monitor: the predictor presents a fresh response every cycle; compare it
  // mid-cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("PredTakenF",   64'(bp_if.PredTakenF),   64'(mon_e.pt));
        check("PredTargetF",  64'(bp_if.PredTargetF),  64'(mon_e.ptgt));
        check("MispredictE",  64'(bp_if.MispredictE),  64'(mon_e.mp));
        check("RedirectPCE",  64'(bp_if.RedirectPCE),  64'(mon_e.rpc));
        check("BranchCount",  64'(bp_if.BranchCount),  64'(mon_e.bc));
        check("MispredCount", 64'(bp_if.MispredCount), 64'(mon_e.mc));
      end
    end
  end

  task automatic set_idle();
    bp_if.PCF           = '0;
    bp_if.ValidE        = 1'b0;
    bp_if.PCE           = '0;
    bp_if.JumpE         = 2'b00;
    bp_if.BranchE       = 2'b00;
    bp_if.PCSrcE        = 2'b00;
    bp_if.ActualTargetE = '0;
    bp_if.PredTakenE    = 1'b0;
    bp_if.PredTargetE   = '0;
  endtask

  // Drive one cycle of stimulus, push the expected response, then train the model.
  task automatic step(input logic [31:0] pcf, input bit ve, input logic [31:0] pce,
                      input logic [1:0] j, input logic [1:0] b, input logic [1:0] src,
                      input logic [31:0] act, input bit pte, input logic [31:0] ptge);
    exp_t e;
    bit   ctrl;
    bit   taken;
    bit   hit_e;
    int   ie;
    @(posedge clk);
    #1;
    bp_if.PCF           = pcf;
    bp_if.ValidE        = ve;
    bp_if.PCE           = pce;
    bp_if.JumpE         = j;
    bp_if.BranchE       = b;
    bp_if.PCSrcE        = src;
    bp_if.ActualTargetE = act;
    bp_if.PredTakenE    = pte;
    bp_if.PredTargetE   = ptge;

    ctrl  = ve && ((j != 2'b00) || (b != 2'b00));
    taken = ctrl && (src != 2'b00);
    ie    = m_idx(pce);
    hit_e = m_hit(pce);

    e.pt   = m_pred_taken(pcf);
    e.ptgt = m_pred_tgt(pcf);
    e.mp   = ve && ((pte != taken) || (taken && pte && (ptge != act)));
    e.rpc  = taken ? act : pce + 32'd4;
    e.bc   = 16'(m_bc);
    e.mc   = 16'(m_mc);
    exp_q.push_back(e);

    if (ctrl) begin
      if (hit_e) begin
        if (taken) begin
          m_ctr[ie] = (m_ctr[ie] < 3) ? m_ctr[ie] + 1 : 3;
          m_tgt[ie] = act;
        end else begin
          m_ctr[ie] = (m_ctr[ie] > 0) ? m_ctr[ie] - 1 : 0;
        end
      end else if (taken) begin
        m_valid[ie] = 1'b1;
        m_tag[ie]   = m_tagof(pce);
        m_tgt[ie]   = act;
        m_ctr[ie]   = 2;
      end
    end else if (ve && hit_e) begin
      m_valid[ie] = 1'b0;
    end
    if (ctrl && (m_bc < CMAX)) m_bc++;
    if (e.mp && (m_mc < CMAX)) m_mc++;
  endtask

  // Resolve a control instruction whose carried prediction is what the table gives now.
  task automatic resolve(input logic [31:0] pce, input logic [1:0] j, input logic [1:0] b,
                         input logic [1:0] src, input logic [31:0] act);
    step(pce, 1'b1, pce, j, b, src, act, m_pred_taken(pce), m_pred_tgt(pce));
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
  endfunction

  // Watchdog: the run is a fixed number of cycles; anything past this is a hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] pc, pcf, act;
    logic [1:0]  j, b, src;
    bit          ve, pte;
    logic [31:0] ptge;
    int          kind;

    set_idle();
    model_reset();
    rst = 1'b0;
    bp_if.PCF = 32'h40;
    #1;
    check("reset PredTakenF",   64'(bp_if.PredTakenF),   64'h0);
    check("reset PredTargetF",  64'(bp_if.PredTargetF),  64'h0);
    check("reset BranchCount",  64'(bp_if.BranchCount),  64'h0);
    check("reset MispredCount", 64'(bp_if.MispredCount), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset lookup, then first beq at 0x40 taken to 0x80 (allocate, ctr=10).
    step(32'h40, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);
    step(32'h40, 1'b1, 32'h40, 2'b00, 2'b01, 2'b01, 32'h80, 1'b0, 32'h0);
    #2;
    check("beq first MispredictE", 64'(bp_if.MispredictE), 64'h1);
    check("beq first RedirectPCE", 64'(bp_if.RedirectPCE), 64'h80);

    // Two more taken (11,11), then two not-taken (10,01).
    resolve(32'h40, 2'b00, 2'b01, 2'b01, 32'h80);
    #2;
    check("beq trained PredTakenF",  64'(bp_if.PredTakenF),  64'h1);
    check("beq trained PredTargetF", 64'(bp_if.PredTargetF), 64'h80);
    resolve(32'h40, 2'b00, 2'b01, 2'b01, 32'h80);
    resolve(32'h40, 2'b00, 2'b01, 2'b00, 32'h80);
    resolve(32'h40, 2'b00, 2'b01, 2'b00, 32'h80);
    #2;
    check("beq not-taken MispredictE", 64'(bp_if.MispredictE), 64'h1);
    check("beq not-taken RedirectPCE", 64'(bp_if.RedirectPCE), 64'h44);
    step(32'h40, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);
    #2;
    check("beq weak PredTakenF", 64'(bp_if.PredTakenF), 64'h0);

    // jal trains 0x100 -> 0x200, then jalr there resolves to 0x300.
    resolve(32'h100, 2'b01, 2'b00, 2'b01, 32'h200);
    step(32'h100, 1'b1, 32'h100, 2'b10, 2'b00, 2'b10, 32'h300, 1'b1, 32'h200);
    #2;
    check("jalr MispredictE", 64'(bp_if.MispredictE), 64'h1);
    check("jalr RedirectPCE", 64'(bp_if.RedirectPCE), 64'h300);
    step(32'h100, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);
    #2;
    check("jalr new PredTargetF", 64'(bp_if.PredTargetF), 64'h300);

    // Aliasing: retrain 0x40, a non-branch at 0x440 misses on tag, one at 0x40 clears it.
    resolve(32'h40, 2'b00, 2'b01, 2'b01, 32'h80);
    step(32'h40, 1'b1, 32'h440, 2'b00, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);
    step(32'h40, 1'b1, 32'h40, 2'b00, 2'b00, 2'b00, 32'h0, 1'b1, 32'h80);
    #2;
    check("alias survives PredTakenF", 64'(bp_if.PredTakenF), 64'h1);
    check("stale alias MispredictE",   64'(bp_if.MispredictE), 64'h1);
    check("stale alias RedirectPCE",   64'(bp_if.RedirectPCE), 64'h44);
    step(32'h40, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);
    #2;
    check("invalidated PredTakenF", 64'(bp_if.PredTakenF), 64'h0);

    // Bubble with junk inputs must not mispredict or count.
    step(32'h100, 1'b0, 32'h200, 2'b01, 2'b01, 2'b01, 32'h999, 1'b1, 32'h5);

    // Random traffic over a small aliasing PC space.
    for (int n = 0; n < 2000; n++) begin
      pc   = rand_pc();
      pcf  = rand_pc();
      kind = $urandom_range(0, 5);
      ve   = (kind != 1);
      j    = 2'b00;
      b    = 2'b00;
      src  = 2'b00;
      case (kind)
        2: begin j = 2'b01; src = 2'b01; end
        3: begin j = 2'b10; src = 2'b10; end
        4: begin b = 2'b01; src = 2'($urandom_range(0, 1)); end
        5: begin b = 2'b10; src = 2'($urandom_range(0, 1)); end
        default: ;
      endcase
      act = 32'h2000 + ($urandom_range(0, 3) << 6);
      if ($urandom_range(0, 9) < 8) begin
        pte  = m_pred_taken(pc);
        ptge = m_pred_tgt(pc);
      end else begin
        pte  = 1'($urandom_range(0, 1));
        ptge = 32'h2000 + ($urandom_range(0, 3) << 6);
      end
      step(pcf, ve, pc, j, b, src, act, pte, ptge);
    end

    // Asynchronous reset in the middle of an update to a trained entry.
    resolve(32'h40, 2'b00, 2'b01, 2'b01, 32'h80);
    resolve(32'h40, 2'b00, 2'b01, 2'b01, 32'h80);
    @(posedge clk);
    #1;
    bp_if.PCF           = 32'h40;
    bp_if.ValidE        = 1'b1;
    bp_if.PCE           = 32'h40;
    bp_if.JumpE         = 2'b00;
    bp_if.BranchE       = 2'b01;
    bp_if.PCSrcE        = 2'b01;
    bp_if.ActualTargetE = 32'h80;
    bp_if.PredTakenE    = 1'b1;
    bp_if.PredTargetE   = 32'h80;
    #1;
    check("pre-reset PredTakenF", 64'(bp_if.PredTakenF), 64'(m_pred_taken(32'h40)));
    #1;
    rst = 1'b0;
    #1;
    check("mid reset PredTakenF",   64'(bp_if.PredTakenF),   64'h0);
    check("mid reset PredTargetF",  64'(bp_if.PredTargetF),  64'h0);
    check("mid reset BranchCount",  64'(bp_if.BranchCount),  64'h0);
    check("mid reset MispredCount", 64'(bp_if.MispredCount), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    rst = 1'b1;

    // Saturation: every resolve is a taken beq carried as not-taken.
    for (int n = 0; n < CMAX + 5; n++) begin
      step(32'h40, 1'b1, 32'h40, 2'b00, 2'b01, 2'b01, 32'h80, 1'b0, 32'h0);
    end
    step(32'h40, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0);
    #2;
    check("saturated BranchCount",  64'(bp_if.BranchCount),  64'hFFFF);
    check("saturated MispredCount", 64'(bp_if.MispredCount), 64'hFFFF);

    @(negedge clk);
    #1;
    check("scoreboard drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
